riot_bus_master: RTL and testbench

RIOT_BUS_MASTER -- requirements
Module: riot_bus_master

---
 rtl/riot_pkg.sv | 17 +
 rtl/riot_sync2.sv | 14 +
 rtl/riot_bus_master.sv | 67 ++++++
 tb/tb_riot_bus_master.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riot_pkg.sv
// riot_pkg: bus-master FSM states, RIOT register address map and a timer-write address helper
package riot_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;
  localparam logic [6:0] DRA = 7'h00;
  localparam logic [6:0] DDRA = 7'h01;
  localparam logic [6:0] DRB = 7'h02;
  localparam logic [6:0] DDRB = 7'h03;
  localparam logic [6:0] TIMER_WR = 7'h14;
  localparam logic [6:0] TIMER_IRQ_EN = 7'h08;
  localparam logic [6:0] TIMER_RD = 7'h04;
  localparam logic [6:0] IRQ_FLAG = 7'h05;
  localparam logic [6:0] EDGE_LO = 7'h04;
  localparam logic [6:0] EDGE_HI = 7'h07;
  function automatic logic [6:0] timer_wr_addr(input logic [1:0] prescale, input logic irq_en);
    return TIMER_WR + {5'd0, prescale} + (irq_en ? TIMER_IRQ_EN : 7'h00);
  endfunction
endpackage

// File: rtl/riot_sync2.sv
// riot_sync2: two-flop synchronizer (CLK, RES_n async low, d async in, q synced out; both flops reset to rst_val)
module riot_sync2 #(
  parameter logic rst_val = 1'b1
) (
  input  logic CLK,
  input  logic RES_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge CLK or negedge RES_n)
    if (!RES_n) {q, meta} <= {2{rst_val}};
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/riot_bus_master.sv
// riot_bus_master: host cmd/rsp handshakes to a one-cycle RIOT chip-select bus (A/Din/Dout/CS/CS_n/R_W_n/RS_n) plus synced IRQ_n -> irq
module riot_bus_master
  import riot_pkg::*;
(
  input  logic       CLK,
  input  logic       RES_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_read,
  input  logic       cmd_ram,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [6:0] A,
  output logic [7:0] Din,
  input  logic [7:0] Dout,
  output logic       CS,
  output logic       CS_n,
  output logic       R_W_n,
  output logic       RS_n,
  input  logic       IRQ_n,
  output logic       irq
);
  state_t state_q, state_d;
  logic run, accept, irq_n_sync;
  assign cmd_ready = run && state_q == IDLE;
  assign accept = cmd_valid && cmd_ready;
  assign CS_n = ~CS;
  assign irq = ~irq_n_sync;
  always_comb begin
    state_d = state_q;
    state_d = state_q == IDLE    ? (accept ? ACCESS : IDLE) :
              state_q == ACCESS  ? (R_W_n ? CAPTURE : IDLE) :
              state_q == CAPTURE ? RESP :
                                   (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge CLK or negedge RES_n)
    if (!RES_n) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge CLK or negedge RES_n)
    if (!RES_n) begin
      run <= 1'b0;
      A <= '0;
      Din <= '0;
      R_W_n <= 1'b1;
      RS_n <= 1'b1;
      CS <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
    end else begin
      run <= 1'b1;
      if (accept) begin
        A <= cmd_addr;
        Din <= cmd_wdata;
        R_W_n <= cmd_read;
        RS_n <= ~cmd_ram;
        CS <= 1'b1;
      end else if (state_q == ACCESS) CS <= 1'b0;
      if (state_q == CAPTURE) begin
        rsp_data <= Dout;
        rsp_valid <= 1'b1;
      end else if (state_q == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  riot_sync2 #(.rst_val(1'b1)) u_irq_sync (.CLK(CLK), .RES_n(RES_n), .d(IRQ_n), .q(irq_n_sync));
endmodule

// File: tb/tb_riot_bus_master.sv
// tb_riot_bus_master: scoreboard bench for riot_bus_master with a RAM/IO peripheral model
module tb_riot_bus_master;
  import riot_pkg::*;
  logic CLK = 0, RES_n = 0;
  logic cmd_valid = 0, cmd_read = 0, cmd_ram = 0, rsp_ready = 0, IRQ_n = 1;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic cmd_ready, rsp_valid, CS, CS_n, R_W_n, RS_n, irq;
  logic [7:0] rsp_data, Din, Dout;
  logic [6:0] A;
  logic [7:0] ram [128];
  logic [7:0] io [128];
  logic [16:0] bus_q [$];
  logic [7:0] rsp_q [$];
  int checks = 0, errors = 0, cs_cnt = 0, cyc = 0;
  riot_bus_master dut (
    .CLK(CLK), .RES_n(RES_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
    .cmd_ram(cmd_ram), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .A(A), .Din(Din), .Dout(Dout), .CS(CS),
    .CS_n(CS_n), .R_W_n(R_W_n), .RS_n(RS_n), .IRQ_n(IRQ_n), .irq(irq)
  );
  always #5 CLK = ~CLK;
  assign Dout = RS_n ? io[A] : ram[A];
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (CS) cs_cnt <= cs_cnt + 1;
    if (CS && !R_W_n) begin
      if (RS_n) io[A] <= Din;
      else ram[A] <= Din;
    end
  end
  task automatic drive(input logic rd, input logic rm, input logic [6:0] ad, input logic [7:0] wd);
    cmd_valid = 1;
    cmd_read = rd;
    cmd_ram = rm;
    cmd_addr = ad;
    cmd_wdata = wd;
    bus_q.push_back({~rm, rd, ad, wd});
  endtask
  task automatic test_reset;
    logic [16:0] e;
    repeat (3) @(negedge CLK);
    checks++;
    if ({cmd_ready, rsp_valid, CS, CS_n, R_W_n, RS_n, irq} !== 7'b0001110) begin
      errors++;
      $display("FAIL reset_ctl got %b exp 0001110", {cmd_ready, rsp_valid, CS, CS_n, R_W_n, RS_n, irq});
    end
    checks++;
    if ({rsp_data, A, Din} !== 23'd0) begin
      errors++;
      $display("FAIL reset_data got %h exp 0", {rsp_data, A, Din});
    end
    RES_n = 1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge got %b exp 0", cmd_ready);
    end
    @(negedge CLK);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_edge got %b exp 1", cmd_ready);
    end
  endtask
  task automatic test_write;
    int c0;
    logic [16:0] e;
    c0 = cs_cnt;
    drive(0, 1, 7'h10, 8'hA5);
    @(negedge CLK);
    cmd_valid = 0;
    e = bus_q.pop_front();
    checks++;
    if ({CS, CS_n, cmd_ready, RS_n, R_W_n, A, Din} !== {3'b100, e}) begin
      errors++;
      $display("FAIL write_bus got %h exp %h", {CS, CS_n, cmd_ready, RS_n, R_W_n, A, Din}, {3'b100, e});
    end
    @(negedge CLK);
    checks++;
    if ({CS, CS_n, cmd_ready} !== 3'b011 || cs_cnt - c0 != 1) begin
      errors++;
      $display("FAIL write_end got cs=%b csn=%b rdy=%b pulses=%0d exp 0 1 1 1", CS, CS_n, cmd_ready, cs_cnt - c0);
    end
  endtask
  task automatic test_read(input logic rm, input logic [6:0] ad, input logic [7:0] exp_d);
    logic [16:0] e;
    logic [7:0] d;
    drive(1, rm, ad, 8'h00);
    rsp_q.push_back(exp_d);
    @(negedge CLK);
    cmd_valid = 0;
    e = bus_q.pop_front();
    checks++;
    if ({CS, RS_n, R_W_n, A} !== {1'b1, e[16:8]}) begin
      errors++;
      $display("FAIL read_bus got %h exp %h", {CS, RS_n, R_W_n, A}, {1'b1, e[16:8]});
    end
    @(negedge CLK);
    checks++;
    if (rsp_valid !== 1'b0 || CS !== 1'b0) begin
      errors++;
      $display("FAIL read_early got vld=%b cs=%b exp 0 0", rsp_valid, CS);
    end
    @(negedge CLK);
    d = rsp_q.pop_front();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== d) begin
      errors++;
      $display("FAIL read_rsp got vld=%b data=%h exp 1 %h", rsp_valid, rsp_data, d);
    end
    rsp_ready = 1;
    @(negedge CLK);
    rsp_ready = 0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL read_done got vld=%b rdy=%b exp 0 1", rsp_valid, cmd_ready);
    end
  endtask
  task automatic test_stall;
    int c0, bad;
    logic [16:0] e;
    logic [7:0] d;
    c0 = cs_cnt;
    bad = 0;
    drive(1, 1, 7'h10, 8'h00);
    rsp_q.push_back(8'hA5);
    @(negedge CLK);
    e = bus_q.pop_front();
    drive(0, 1, 7'h11, 8'h77);
    @(negedge CLK);
    @(negedge CLK);
    d = rsp_q.pop_front();
    repeat (5) begin
      if (rsp_valid !== 1'b1 || rsp_data !== d || cmd_ready !== 1'b0 || A !== e[14:8]) bad++;
      @(negedge CLK);
    end
    checks++;
    if (bad != 0 || cs_cnt - c0 != 1) begin
      errors++;
      $display("FAIL stall_hold got bad_cycles=%0d pulses=%0d exp 0 1", bad, cs_cnt - c0);
    end
    rsp_ready = 1;
    @(negedge CLK);
    rsp_ready = 0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || CS !== 1'b0) begin
      errors++;
      $display("FAIL stall_release got vld=%b rdy=%b cs=%b exp 0 1 0", rsp_valid, cmd_ready, CS);
    end
    @(negedge CLK);
    cmd_valid = 0;
    e = bus_q.pop_front();
    checks++;
    if ({CS, RS_n, R_W_n, A, Din} !== {1'b1, e}) begin
      errors++;
      $display("FAIL stall_next_write got %h exp %h", {CS, RS_n, R_W_n, A, Din}, {1'b1, e});
    end
    @(negedge CLK);
  endtask
  task automatic test_back_to_back;
    int t0;
    logic [16:0] e;
    drive(0, 0, DDRA, 8'hFF);
    @(negedge CLK);
    t0 = cyc;
    e = bus_q.pop_front();
    checks++;
    if ({CS, RS_n, R_W_n, A, Din} !== {1'b1, e}) begin
      errors++;
      $display("FAIL b2b_first got %h exp %h", {CS, RS_n, R_W_n, A, Din}, {1'b1, e});
    end
    drive(0, 0, DRA, 8'h3C);
    @(negedge CLK);
    checks++;
    if (CS !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap got cs=%b rdy=%b exp 0 1", CS, cmd_ready);
    end
    @(negedge CLK);
    cmd_valid = 0;
    e = bus_q.pop_front();
    checks++;
    if ({CS, RS_n, R_W_n, A, Din} !== {1'b1, e} || cyc - t0 != 2) begin
      errors++;
      $display("FAIL b2b_second got %h gap=%0d exp %h 2", {CS, RS_n, R_W_n, A, Din}, cyc - t0, {1'b1, e});
    end
    @(negedge CLK);
  endtask
  task automatic test_reset_abort;
    int bad;
    logic [16:0] e;
    bad = 0;
    drive(1, 1, 7'h10, 8'h00);
    @(negedge CLK);
    cmd_valid = 0;
    e = bus_q.pop_front();
    RES_n = 0;
    #1;
    checks++;
    if ({CS, CS_n, rsp_valid} !== 3'b010) begin
      errors++;
      $display("FAIL abort_async got cs=%b csn=%b vld=%b exp 0 1 0", CS, CS_n, rsp_valid);
    end
    @(negedge CLK);
    @(negedge CLK);
    RES_n = 1;
    @(negedge CLK);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_ready got %b exp 1", cmd_ready);
    end
    repeat (4) begin
      if (rsp_valid !== 1'b0 || CS !== 1'b0) bad++;
      @(negedge CLK);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort_no_rsp got bad_cycles=%0d exp 0", bad);
    end
  endtask
  task automatic test_irq;
    logic [16:0] e;
    drive(0, 0, DRB, 8'h5A);
    IRQ_n = 0;
    @(negedge CLK);
    cmd_valid = 0;
    e = bus_q.pop_front();
    checks++;
    if (irq !== 1'b0 || {CS, RS_n, R_W_n, A, Din} !== {1'b1, e}) begin
      errors++;
      $display("FAIL irq_one_edge got irq=%b bus=%h exp 0 %h", irq, {CS, RS_n, R_W_n, A, Din}, {1'b1, e});
    end
    @(negedge CLK);
    checks++;
    if (irq !== 1'b1 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL irq_two_edges got irq=%b rdy=%b exp 1 1", irq, cmd_ready);
    end
    IRQ_n = 1;
    @(negedge CLK);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_hold got %b exp 1", irq);
    end
    @(negedge CLK);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear got %b exp 0", irq);
    end
  endtask
  initial begin
    for (int i = 0; i < 128; i++) begin
      ram[i] = 8'h00;
      io[i] = 8'h00;
    end
    test_reset;
    test_write;
    test_read(1, 7'h10, 8'hA5);
    test_irq;
    test_read(0, DRB, 8'h5A);
    test_stall;
    test_back_to_back;
    test_read(0, DRA, 8'h3C);
    test_reset_abort;
    test_read(1, 7'h11, 8'h77);
    checks++;
    if (bus_q.size() != 0 || rsp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got bus=%0d rsp=%0d exp 0 0", bus_q.size(), rsp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
